// File: rtl/qpu_exu_disp_if.sv
// Dispatch-stage bus: decoder-side instruction handshake and ALU-side issue handshake.
// slave = dispatch stage view, master = surrounding pipeline (decoder + ALU) view.
interface qpu_exu_disp_if #(
  parameter int XLEN         = 32,
  parameter int PC_SIZE      = 32,
  parameter int RFIDX_W      = 5,
  parameter int DECINFO_W    = 32,
  parameter int TIME_W       = 32,
  parameter int QUBIT_NUM    = 8,
  parameter int EVENT_WIRE_W = 66,
  parameter int EVENT_NUM    = 8
);
  logic                    disp_i_valid;
  logic                    disp_i_ready;
  logic                    disp_i_rs1x0;
  logic                    disp_i_rs2x0;
  logic                    disp_i_rs1en;
  logic                    disp_i_rs2en;
  logic                    disp_i_rdwen;
  logic [RFIDX_W-1:0]      disp_i_rs1idx;
  logic [RFIDX_W-1:0]      disp_i_rs2idx;
  logic [RFIDX_W-1:0]      disp_i_rdidx;
  logic [XLEN-1:0]         disp_i_rs1;
  logic [XLEN-1:0]         disp_i_rs2;
  logic [DECINFO_W-1:0]    disp_i_info;
  logic [XLEN-1:0]         disp_i_imm;
  logic [PC_SIZE-1:0]      disp_i_pc;
  logic                    disp_i_ntp;
  logic                    disp_i_measure;
  logic                    disp_i_nqf;
  logic                    disp_i_fmr;
  logic [TIME_W-1:0]       disp_i_clk;
  logic [QUBIT_NUM-1:0]    disp_i_qmr;
  logic [EVENT_WIRE_W-1:0] disp_i_edata;
  logic [EVENT_NUM-1:0]    disp_i_oprand;

  logic                    disp_o_alu_valid;
  logic                    disp_o_alu_ready;
  logic                    disp_o_alu_longpipe;
  logic [XLEN-1:0]         disp_o_alu_rs1;
  logic [XLEN-1:0]         disp_o_alu_rs2;
  logic                    disp_o_alu_rdwen;
  logic [RFIDX_W-1:0]      disp_o_alu_rdidx;
  logic [DECINFO_W-1:0]    disp_o_alu_info;
  logic [XLEN-1:0]         disp_o_alu_imm;
  logic [PC_SIZE-1:0]      disp_o_alu_pc;
  logic [TIME_W-1:0]       disp_o_alu_clk;
  logic [QUBIT_NUM-1:0]    disp_o_alu_qmr;
  logic [EVENT_WIRE_W-1:0] disp_o_alu_edata;
  logic [EVENT_NUM-1:0]    disp_o_alu_oprand;
  logic                    disp_o_alu_ntp;
  logic                    disp_o_alu_fmr;
  logic                    disp_o_alu_measure;

  modport slave (
    input  disp_i_valid, disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en,
           disp_i_rdwen, disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx, disp_i_rs1,
           disp_i_rs2, disp_i_info, disp_i_imm, disp_i_pc, disp_i_ntp, disp_i_measure,
           disp_i_nqf, disp_i_fmr, disp_i_clk, disp_i_qmr, disp_i_edata, disp_i_oprand,
           disp_o_alu_ready, disp_o_alu_longpipe,
    output disp_i_ready,
           disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_rdwen,
           disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc,
           disp_o_alu_clk, disp_o_alu_qmr, disp_o_alu_edata, disp_o_alu_oprand,
           disp_o_alu_ntp, disp_o_alu_fmr, disp_o_alu_measure
  );

  modport master (
    output disp_i_valid, disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en,
           disp_i_rdwen, disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx, disp_i_rs1,
           disp_i_rs2, disp_i_info, disp_i_imm, disp_i_pc, disp_i_ntp, disp_i_measure,
           disp_i_nqf, disp_i_fmr, disp_i_clk, disp_i_qmr, disp_i_edata, disp_i_oprand,
           disp_o_alu_ready, disp_o_alu_longpipe,
    input  disp_i_ready,
           disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_rdwen,
           disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc,
           disp_o_alu_clk, disp_o_alu_qmr, disp_o_alu_edata, disp_o_alu_oprand,
           disp_o_alu_ntp, disp_o_alu_fmr, disp_o_alu_measure
  );
endinterface

// File: rtl/qpu_exu_disp.sv
// QPU execution-unit dispatch: hazard check against OITF, ALU issue, OITF/MOITF allocation.
// Optional QPU_DISP_X0_ZERO_EN: force ALU operands to zero when the source register is x0.
module qpu_exu_disp #(
  parameter int XLEN         = 32,
  parameter int PC_SIZE      = 32,
  parameter int RFIDX_W      = 5,
  parameter int DECINFO_W    = 32,
  parameter int TIME_W       = 32,
  parameter int QUBIT_NUM    = 8,
  parameter int EVENT_WIRE_W = 66,
  parameter int EVENT_NUM    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qpu_exu_disp_if.slave        disp,

  input  logic                 oitfrd_match_disprs1,
  input  logic                 oitfrd_match_disprs2,
  input  logic                 oitfrd_match_disprd,
  input  logic                 oitfqf_match_dispql,

  output logic                 disp_oitf_ena,
  output logic                 disp_moitf_ena,
  input  logic                 disp_oitf_ready,
  input  logic                 disp_moitf_ready,

  output logic                 disp_oitf_rs1en,
  output logic                 disp_oitf_rs2en,
  output logic                 disp_oitf_rdwen,
  output logic                 disp_oitf_qfren,
  output logic [RFIDX_W-1:0]   disp_oitf_rs1idx,
  output logic [RFIDX_W-1:0]   disp_oitf_rs2idx,
  output logic [RFIDX_W-1:0]   disp_oitf_rdidx,
  output logic [QUBIT_NUM-1:0] disp_oitf_qubitlist
);

  logic live;
  logic dep;
  logic cond;

  // live drops asynchronously with rst_n, so valid/ready fall in the reset cycle itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_comb begin
    dep  = (disp.disp_i_rs1en & oitfrd_match_disprs1)
         | (disp.disp_i_rs2en & oitfrd_match_disprs2)
         | (disp.disp_i_rdwen & oitfrd_match_disprd)
         | (disp.disp_i_nqf   & oitfqf_match_dispql);
    cond = live & ~dep
         & (~disp.disp_o_alu_longpipe | disp_oitf_ready)
         & (~disp.disp_i_measure      | disp_moitf_ready);
  end

  assign disp.disp_o_alu_valid = disp.disp_i_valid & cond;
  assign disp.disp_i_ready     = disp.disp_o_alu_ready & cond;

  assign disp_oitf_ena  = disp.disp_o_alu_valid & disp.disp_o_alu_ready & disp.disp_o_alu_longpipe;
  assign disp_moitf_ena = disp.disp_o_alu_valid & disp.disp_o_alu_ready & disp.disp_i_measure;

`ifdef QPU_DISP_X0_ZERO_EN
  assign disp.disp_o_alu_rs1 = disp.disp_i_rs1x0 ? '0 : disp.disp_i_rs1;
  assign disp.disp_o_alu_rs2 = disp.disp_i_rs2x0 ? '0 : disp.disp_i_rs2;
`else
  logic unused_x0;
  assign unused_x0 = &{1'b0, disp.disp_i_rs1x0, disp.disp_i_rs2x0};
  assign disp.disp_o_alu_rs1 = disp.disp_i_rs1;
  assign disp.disp_o_alu_rs2 = disp.disp_i_rs2;
`endif

  assign disp.disp_o_alu_rdwen   = disp.disp_i_rdwen;
  assign disp.disp_o_alu_rdidx   = disp.disp_i_rdidx;
  assign disp.disp_o_alu_info    = disp.disp_i_info;
  assign disp.disp_o_alu_imm     = disp.disp_i_imm;
  assign disp.disp_o_alu_pc      = disp.disp_i_pc;
  assign disp.disp_o_alu_clk     = disp.disp_i_clk;
  assign disp.disp_o_alu_qmr     = disp.disp_i_qmr;
  assign disp.disp_o_alu_edata   = disp.disp_i_edata;
  assign disp.disp_o_alu_oprand  = disp.disp_i_oprand;
  assign disp.disp_o_alu_ntp     = disp.disp_i_ntp;
  assign disp.disp_o_alu_fmr     = disp.disp_i_fmr;
  assign disp.disp_o_alu_measure = disp.disp_i_measure;

  assign disp_oitf_rs1en  = disp.disp_i_rs1en;
  assign disp_oitf_rs2en  = disp.disp_i_rs2en;
  assign disp_oitf_rdwen  = disp.disp_i_rdwen;
  assign disp_oitf_qfren  = disp.disp_i_nqf;
  assign disp_oitf_rs1idx = disp.disp_i_rs1idx;
  assign disp_oitf_rs2idx = disp.disp_i_rs2idx;
  assign disp_oitf_rdidx  = disp.disp_i_rdidx;

  // measure and FMR carry their target qubit mask in the low immediate bits
  assign disp_oitf_qubitlist = (disp.disp_i_measure | disp.disp_i_fmr)
                             ? disp.disp_i_imm[QUBIT_NUM-1:0] : '0;

endmodule

// File: tb/tb_qpu_exu_disp.sv
// Self-checking bench for qpu_exu_disp: vector table, hand sequences and random vs. reference model.
module tb_qpu_exu_disp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpu_exu_disp_if dif ();

  logic       m_rs1, m_rs2, m_rd, m_qf;
  logic       oitf_ready, moitf_ready;
  logic       oitf_ena, moitf_ena;
  logic       o_rs1en, o_rs2en, o_rdwen, o_qfren;
  logic [4:0] o_rs1idx, o_rs2idx, o_rdidx;
  logic [7:0] o_qlist;

  qpu_exu_disp #(
    .XLEN(32), .PC_SIZE(32), .RFIDX_W(5), .DECINFO_W(32),
    .TIME_W(32), .QUBIT_NUM(8), .EVENT_WIRE_W(66), .EVENT_NUM(8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .disp                 (dif),
    .oitfrd_match_disprs1 (m_rs1),
    .oitfrd_match_disprs2 (m_rs2),
    .oitfrd_match_disprd  (m_rd),
    .oitfqf_match_dispql  (m_qf),
    .disp_oitf_ena        (oitf_ena),
    .disp_moitf_ena       (moitf_ena),
    .disp_oitf_ready      (oitf_ready),
    .disp_moitf_ready     (moitf_ready),
    .disp_oitf_rs1en      (o_rs1en),
    .disp_oitf_rs2en      (o_rs2en),
    .disp_oitf_rdwen      (o_rdwen),
    .disp_oitf_qfren      (o_qfren),
    .disp_oitf_rs1idx     (o_rs1idx),
    .disp_oitf_rs2idx     (o_rs2idx),
    .disp_oitf_rdidx      (o_rdidx),
    .disp_oitf_qubitlist  (o_qlist)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          exp_live = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    dif.disp_i_valid = 1'b1;   dif.disp_o_alu_ready = 1'b1; dif.disp_o_alu_longpipe = 1'b0;
    dif.disp_i_rs1x0 = 1'b0;   dif.disp_i_rs2x0 = 1'b0;
    dif.disp_i_rs1en = 1'b0;   dif.disp_i_rs2en = 1'b0;     dif.disp_i_rdwen = 1'b0;
    dif.disp_i_rs1idx = 5'd1;  dif.disp_i_rs2idx = 5'd2;    dif.disp_i_rdidx = 5'd3;
    dif.disp_i_rs1 = 32'h1111; dif.disp_i_rs2 = 32'h2222;
    dif.disp_i_info = 32'h0;   dif.disp_i_imm = 32'h0;      dif.disp_i_pc = 32'h8000_0000;
    dif.disp_i_ntp = 1'b0;     dif.disp_i_measure = 1'b0;   dif.disp_i_nqf = 1'b0;
    dif.disp_i_fmr = 1'b0;     dif.disp_i_clk = 32'h0;      dif.disp_i_qmr = 8'h0;
    dif.disp_i_edata = 66'h0;  dif.disp_i_oprand = 8'h0;
    m_rs1 = 1'b0; m_rs2 = 1'b0; m_rd = 1'b0; m_qf = 1'b0;
    oitf_ready = 1'b1; moitf_ready = 1'b1;
  endtask

  // Reference model: an instruction goes only if the stage is live and no stall reason applies.
  task automatic check_all(input string tag);
    bit stall_reasons[$];
    bit go, e_valid, e_ready;
    logic [31:0] e_rs1, e_rs2;
    stall_reasons.push_back(dif.disp_i_rs1en && m_rs1);
    stall_reasons.push_back(dif.disp_i_rs2en && m_rs2);
    stall_reasons.push_back(dif.disp_i_rdwen && m_rd);
    stall_reasons.push_back(dif.disp_i_nqf && m_qf);
    stall_reasons.push_back(dif.disp_o_alu_longpipe && !oitf_ready);
    stall_reasons.push_back(dif.disp_i_measure && !moitf_ready);
    go = exp_live;
    foreach (stall_reasons[k]) if (stall_reasons[k]) go = 1'b0;
    e_valid = go && dif.disp_i_valid;
    e_ready = go && dif.disp_o_alu_ready;
`ifdef QPU_DISP_X0_ZERO_EN
    e_rs1 = dif.disp_i_rs1x0 ? 32'h0 : dif.disp_i_rs1;
    e_rs2 = dif.disp_i_rs2x0 ? 32'h0 : dif.disp_i_rs2;
`else
    e_rs1 = dif.disp_i_rs1;
    e_rs2 = dif.disp_i_rs2;
`endif
    chk({tag, ".alu_valid"}, 128'(dif.disp_o_alu_valid), 128'(e_valid));
    chk({tag, ".i_ready"},   128'(dif.disp_i_ready),     128'(e_ready));
    chk({tag, ".oitf_ena"},  128'(oitf_ena),  128'(e_valid && dif.disp_o_alu_ready && dif.disp_o_alu_longpipe));
    chk({tag, ".moitf_ena"}, 128'(moitf_ena), 128'(e_valid && dif.disp_o_alu_ready && dif.disp_i_measure));
    chk({tag, ".qlist"}, 128'(o_qlist),
        (dif.disp_i_measure || dif.disp_i_fmr) ? 128'(dif.disp_i_imm % 256) : 128'(0));
    chk({tag, ".rs1"}, 128'(dif.disp_o_alu_rs1), 128'(e_rs1));
    chk({tag, ".rs2"}, 128'(dif.disp_o_alu_rs2), 128'(e_rs2));
    chk({tag, ".pass"},
        {dif.disp_o_alu_pc, dif.disp_o_alu_info, dif.disp_o_alu_imm, dif.disp_o_alu_clk},
        {dif.disp_i_pc, dif.disp_i_info, dif.disp_i_imm, dif.disp_i_clk});
    chk({tag, ".edata"}, 128'(dif.disp_o_alu_edata), 128'(dif.disp_i_edata));
    chk({tag, ".misc"},
        128'({dif.disp_o_alu_qmr, dif.disp_o_alu_oprand, dif.disp_o_alu_rdidx, dif.disp_o_alu_rdwen,
              dif.disp_o_alu_ntp, dif.disp_o_alu_fmr, dif.disp_o_alu_measure}),
        128'({dif.disp_i_qmr, dif.disp_i_oprand, dif.disp_i_rdidx, dif.disp_i_rdwen,
              dif.disp_i_ntp, dif.disp_i_fmr, dif.disp_i_measure}));
    chk({tag, ".oitf_fields"},
        128'({o_rs1en, o_rs2en, o_rdwen, o_qfren, o_rs1idx, o_rs2idx, o_rdidx}),
        128'({dif.disp_i_rs1en, dif.disp_i_rs2en, dif.disp_i_rdwen, dif.disp_i_nqf,
              dif.disp_i_rs1idx, dif.disp_i_rs2idx, dif.disp_i_rdidx}));
  endtask

  typedef struct {
    string    name;
    bit       v, ar, lp, ordy, mrdy, e1, m1, e2, m2, ew, mw, nq, mq, ms, fm;
    bit [7:0] imm;
    bit       xv, xr, xo, xm;
    bit [7:0] xq;
  } vec_t;

  vec_t tbl[$];

  initial begin
    //                 name               v ar lp or mr e1 m1 e2 m2 ew mw nq mq ms fm imm    xv xr xo xm xq
    tbl.push_back('{"all_go",           1,1,0,1,1, 0,0,0,0,0,0,0,0,0,0, 8'h00, 1,1,0,0,8'h00});
    tbl.push_back('{"rs1_hazard",       1,1,0,1,1, 1,1,0,0,0,0,0,0,0,0, 8'h00, 0,0,0,0,8'h00});
    tbl.push_back('{"rs1_match_no_en",  1,1,0,1,1, 0,1,0,0,0,0,0,0,0,0, 8'h00, 1,1,0,0,8'h00});
    tbl.push_back('{"rs2_hazard",       1,1,0,1,1, 0,0,1,1,0,0,0,0,0,0, 8'h00, 0,0,0,0,8'h00});
    tbl.push_back('{"rd_hazard",        1,1,0,1,1, 0,0,0,0,1,1,0,0,0,0, 8'h00, 0,0,0,0,8'h00});
    tbl.push_back('{"qf_hazard",        1,1,0,1,1, 0,0,0,0,0,0,1,1,0,0, 8'h00, 0,0,0,0,8'h00});
    tbl.push_back('{"qf_match_no_nqf",  1,1,0,1,1, 0,0,0,0,0,0,0,1,0,0, 8'h00, 1,1,0,0,8'h00});
    tbl.push_back('{"longpipe_full",    1,1,1,0,1, 0,0,0,0,0,0,0,0,0,0, 8'h00, 0,0,0,0,8'h00});
    tbl.push_back('{"longpipe_alloc",   1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0, 8'h00, 1,1,1,0,8'h00});
    tbl.push_back('{"meas_moitf_full",  1,1,0,1,0, 0,0,0,0,0,0,0,0,1,0, 8'h3c, 0,0,0,0,8'h3c});
    tbl.push_back('{"meas_alloc",       1,1,0,1,1, 0,0,0,0,0,0,0,0,1,0, 8'h3c, 1,1,0,1,8'h3c});
    tbl.push_back('{"fmr_qlist",        1,1,0,1,1, 0,0,0,0,0,0,0,0,0,1, 8'h05, 1,1,0,0,8'h05});
    tbl.push_back('{"alu_not_ready",    1,0,1,1,1, 0,0,0,0,0,0,0,0,0,0, 8'h00, 1,0,0,0,8'h00});
    tbl.push_back('{"no_valid",         0,1,1,1,1, 0,0,0,0,0,0,0,0,0,0, 8'h00, 0,1,0,0,8'h00});
    tbl.push_back('{"multi_hazard",     1,1,0,1,0, 1,1,1,1,0,0,0,0,1,0, 8'h81, 0,0,0,0,8'h81});
    tbl.push_back('{"plain_imm_noq",    1,1,0,1,1, 0,0,0,0,0,0,0,0,0,0, 8'hff, 1,1,0,0,8'h00});

    // Reset: stage is dead while rst_n is low and for the cycle before the first edge after release.
    set_defaults();
    exp_live = 1'b0;
    #2;
    chk("reset.alu_valid", 128'(dif.disp_o_alu_valid), 128'(0));
    chk("reset.i_ready",   128'(dif.disp_i_ready),     128'(0));
    check_all("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("released_no_edge.alu_valid", 128'(dif.disp_o_alu_valid), 128'(0));
    @(posedge clk); #1;
    exp_live = 1'b1;
    chk("live.alu_valid", 128'(dif.disp_o_alu_valid), 128'(1));
    chk("live.i_ready",   128'(dif.disp_i_ready),     128'(1));

    // Table vectors
    foreach (tbl[i]) begin
      @(negedge clk);
      set_defaults();
      dif.disp_i_valid = tbl[i].v;   dif.disp_o_alu_ready = tbl[i].ar;
      dif.disp_o_alu_longpipe = tbl[i].lp;
      oitf_ready = tbl[i].ordy;      moitf_ready = tbl[i].mrdy;
      dif.disp_i_rs1en = tbl[i].e1;  m_rs1 = tbl[i].m1;
      dif.disp_i_rs2en = tbl[i].e2;  m_rs2 = tbl[i].m2;
      dif.disp_i_rdwen = tbl[i].ew;  m_rd  = tbl[i].mw;
      dif.disp_i_nqf   = tbl[i].nq;  m_qf  = tbl[i].mq;
      dif.disp_i_measure = tbl[i].ms; dif.disp_i_fmr = tbl[i].fm;
      dif.disp_i_imm = {24'h0, tbl[i].imm};
      #1;
      chk({tbl[i].name, ".alu_valid"}, 128'(dif.disp_o_alu_valid), 128'(tbl[i].xv));
      chk({tbl[i].name, ".i_ready"},   128'(dif.disp_i_ready),     128'(tbl[i].xr));
      chk({tbl[i].name, ".oitf_ena"},  128'(oitf_ena),             128'(tbl[i].xo));
      chk({tbl[i].name, ".moitf_ena"}, 128'(moitf_ena),            128'(tbl[i].xm));
      chk({tbl[i].name, ".qlist"},     128'(o_qlist),              128'(tbl[i].xq));
    end

    // Hazard clears mid-cycle: dispatch follows with no bubble.
    @(negedge clk);
    set_defaults();
    dif.disp_i_rs1en = 1'b1; m_rs1 = 1'b1;
    #1;
    chk("add_stall.alu_valid", 128'(dif.disp_o_alu_valid), 128'(0));
    chk("add_stall.i_ready",   128'(dif.disp_i_ready),     128'(0));
    #1 m_rs1 = 1'b0;
    #1;
    chk("add_clear.alu_valid", 128'(dif.disp_o_alu_valid), 128'(1));
    chk("add_clear.i_ready",   128'(dif.disp_i_ready),     128'(1));

    // Measure waits for MOITF, then allocates both OITF and MOITF.
    @(negedge clk);
    set_defaults();
    dif.disp_i_measure = 1'b1; moitf_ready = 1'b0; dif.disp_i_imm = 32'h0000_00a5;
    #1;
    chk("meas_stall.alu_valid", 128'(dif.disp_o_alu_valid), 128'(0));
    @(negedge clk);
    moitf_ready = 1'b1; dif.disp_o_alu_longpipe = 1'b1; oitf_ready = 1'b1;
    #1;
    chk("meas_go.oitf_ena",    128'(oitf_ena),  128'(1));
    chk("meas_go.moitf_ena",   128'(moitf_ena), 128'(1));
    chk("meas_go.alu_measure", 128'(dif.disp_o_alu_measure), 128'(1));
    check_all("meas_go");

    // FMR with qubit-flag hazard.
    @(negedge clk);
    set_defaults();
    dif.disp_i_fmr = 1'b1; dif.disp_i_nqf = 1'b1; m_qf = 1'b1; dif.disp_i_imm = 32'h5;
    #1;
    chk("fmr_stall.alu_valid", 128'(dif.disp_o_alu_valid), 128'(0));
    chk("fmr_stall.qfren",     128'(o_qfren), 128'(1));
    chk("fmr_stall.qlist",     128'(o_qlist), 128'(8'h05));

    // QWAIT timing fields and ntp pass-through.
    @(negedge clk);
    set_defaults();
    dif.disp_i_clk = 32'd6; dif.disp_i_qmr = 8'b10; dif.disp_i_ntp = 1'b1;
    #1;
    chk("qwait.alu_clk", 128'(dif.disp_o_alu_clk), 128'(6));
    chk("qwait.alu_qmr", 128'(dif.disp_o_alu_qmr), 128'(2));
    chk("qwait.ntp1",    128'(dif.disp_o_alu_ntp), 128'(1));
    dif.disp_i_ntp = 1'b0;
    #1;
    chk("qwait.ntp0",    128'(dif.disp_o_alu_ntp), 128'(0));

    // x0 operand forcing depends on the build option.
    @(negedge clk);
    set_defaults();
    dif.disp_i_rs1x0 = 1'b1; dif.disp_i_rs1 = 32'hdead;
    #1;
`ifdef QPU_DISP_X0_ZERO_EN
    chk("x0.alu_rs1", 128'(dif.disp_o_alu_rs1), 128'(0));
`else
    chk("x0.alu_rs1", 128'(dif.disp_o_alu_rs1), 128'(32'hdead));
`endif

    // Reset asserted mid-stream: valid/ready drop at once, data still flows.
    @(negedge clk);
    set_defaults();
    dif.disp_i_pc = 32'h1234_5678;
    #1;
    chk("pre_midreset.alu_valid", 128'(dif.disp_o_alu_valid), 128'(1));
    rst_n = 1'b0; exp_live = 1'b0;
    #1;
    chk("midreset.alu_valid", 128'(dif.disp_o_alu_valid), 128'(0));
    chk("midreset.i_ready",   128'(dif.disp_i_ready),     128'(0));
    chk("midreset.alu_pc",    128'(dif.disp_o_alu_pc),    128'(32'h1234_5678));
    check_all("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_live = 1'b1;
    check_all("post_midreset");

    // Randomised stimulus against the reference model.
    for (int unsigned n = 0; n < 300; n++) begin
      @(negedge clk);
      dif.disp_i_valid = 1'($urandom_range(0, 3) != 0);
      dif.disp_o_alu_ready = 1'($urandom_range(0, 3) != 0);
      dif.disp_o_alu_longpipe = 1'($urandom_range(0, 1));
      oitf_ready  = 1'($urandom_range(0, 3) != 0);
      moitf_ready = 1'($urandom_range(0, 3) != 0);
      dif.disp_i_rs1x0 = 1'($urandom_range(0, 1));
      dif.disp_i_rs2x0 = 1'($urandom_range(0, 1));
      dif.disp_i_rs1en = 1'($urandom_range(0, 1));
      dif.disp_i_rs2en = 1'($urandom_range(0, 1));
      dif.disp_i_rdwen = 1'($urandom_range(0, 1));
      dif.disp_i_nqf   = 1'($urandom_range(0, 1));
      m_rs1 = 1'($urandom_range(0, 3) == 0);
      m_rs2 = 1'($urandom_range(0, 3) == 0);
      m_rd  = 1'($urandom_range(0, 3) == 0);
      m_qf  = 1'($urandom_range(0, 3) == 0);
      dif.disp_i_measure = 1'($urandom_range(0, 1));
      dif.disp_i_fmr     = 1'($urandom_range(0, 1));
      dif.disp_i_ntp     = 1'($urandom_range(0, 1));
      dif.disp_i_rs1idx = 5'($urandom); dif.disp_i_rs2idx = 5'($urandom);
      dif.disp_i_rdidx  = 5'($urandom);
      dif.disp_i_rs1 = $urandom; dif.disp_i_rs2 = $urandom;
      dif.disp_i_info = $urandom; dif.disp_i_imm = $urandom; dif.disp_i_pc = $urandom;
      dif.disp_i_clk = $urandom; dif.disp_i_qmr = 8'($urandom);
      dif.disp_i_edata = 66'({$urandom, $urandom, $urandom});
      dif.disp_i_oprand = 8'($urandom);
      #1;
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qpu_exu_disp.md
# qpu_exu_disp

Dispatch stage of the QPU execution unit, between the instruction decoder and the ALU/OITF. Each cycle it takes one decoded instruction, either classical or quantum, together with its register-file operands. It checks for register and qubit-flag hazards against the OITF. It then issues the instruction to the ALU with a valid/ready handshake and allocates OITF/MOITF entries for long-pipe and measure instructions.

## Interface
Parameters:
- XLEN, 32, classical data width
- PC_SIZE, 32, PC width
- RFIDX_W, 5, register index width
- DECINFO_W, 32, decode-info bus width
- TIME_W, 32, timing-register width
- QUBIT_NUM, 8, qubit count
- EVENT_WIRE_W, 66, event-data width
- EVENT_NUM, 8, event operand width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- disp_i_valid / disp_i_ready  in/out  1  upstream handshake
- disp_i_rs1x0, disp_i_rs2x0  in  1  source register is x0
- disp_i_rs1en, disp_i_rs2en, disp_i_rdwen  in  1  source-read enables and rd-write enable
- disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx  in  RFIDX_W  register indices
- disp_i_rs1, disp_i_rs2  in  XLEN  register-file read data
- disp_i_info  in  DECINFO_W; disp_i_imm  in  XLEN; disp_i_pc  in  PC_SIZE
- disp_i_ntp, disp_i_measure, disp_i_nqf, disp_i_fmr  in  1  flags: new timepoint, measure, needs qubit flag, FMR
- disp_i_clk  in  TIME_W; disp_i_qmr  in  QUBIT_NUM; disp_i_edata  in  EVENT_WIRE_W; disp_i_oprand  in  EVENT_NUM
- disp_o_alu_valid  out  1; disp_o_alu_ready  in  1; disp_o_alu_longpipe  in  1
- disp_o_alu_rs1, disp_o_alu_rs2  out  XLEN; disp_o_alu_rdwen  out  1; disp_o_alu_rdidx  out  RFIDX_W
- disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc  out  widths as the matching inputs
- disp_o_alu_clk, disp_o_alu_qmr, disp_o_alu_edata, disp_o_alu_oprand  out  widths as the matching inputs
- disp_o_alu_ntp, disp_o_alu_fmr, disp_o_alu_measure  out  1
- oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql  in  1  OITF hazard matches
- disp_oitf_ena, disp_moitf_ena  out  1; disp_oitf_ready, disp_moitf_ready  in  1
- disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen, disp_oitf_qfren  out  1
- disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx  out  RFIDX_W; disp_oitf_qubitlist  out  QUBIT_NUM

## Operation
- dep = (rs1en & match_rs1) | (rs2en & match_rs2) | (rdwen & match_rd) | (nqf & oitfqf_match_dispql).
- cond = live & ~dep & (~alu_longpipe | oitf_ready) & (~measure | moitf_ready).
- disp_o_alu_valid = disp_i_valid & cond.
- disp_i_ready = disp_o_alu_ready & cond.
- disp_oitf_ena = alu_valid & alu_ready & alu_longpipe.
- disp_moitf_ena = alu_valid & alu_ready & disp_i_measure.
- Operands: alu_rs1 = rs1x0 ? 0 : disp_i_rs1. alu_rs2 is formed the same way.
- Pass-through: rdwen, rdidx, info, imm, pc, clk, qmr, edata, oprand, ntp, fmr, measure.
- OITF fields: rs1en, rs2en, rdwen and the three indices pass through. qfren = disp_i_nqf.
- qubitlist = (measure | fmr) ? imm[QUBIT_NUM-1:0] : 0.
- The block holds no instruction state. Its only state is the flag `live`.

## Timing
- The datapath is fully combinational, with zero-cycle latency.
- `live`: cleared asynchronously while rst_n=0; set on the first clk rising edge after rst_n rises.
- While live=0:
  - alu_valid, disp_i_ready, oitf_ena and moitf_ena are 0.
  - The data outputs still follow their inputs.
- Reset asserted mid-stream drops both valid and ready immediately. No transfer completes in that cycle.
- A transfer occurs on a clk edge when alu_valid & alu_ready = 1.
- When a hazard clears, dispatch happens in the same cycle. No bubble is inserted.
- If several hazards occur at once, any single hazard stalls dispatch.
- A stalled instruction is not dropped; the upstream stage must hold it.

## Configuration
- QPU_DISP_X0_ZERO_EN:
  - Defined: operands are forced to 0 when rsNx0=1.
  - Undefined: alu_rs1/rs2 equal disp_i_rs1/rs2 unconditionally, and rs1x0/rs2x0 are ignored.

## Test plan
- Reset: rst_n=0, valid=1, all ready inputs=1 -> alu_valid=0, disp_i_ready=0. After release and one clk edge: alu_valid=1, disp_i_ready=1.
- ADD, rs1en=1, match_rs1=1 -> alu_valid=0, ready=0. Dropping match_rs1 -> both 1 in the same cycle.
- Measure, moitf_ready=0 -> stall. moitf_ready=1, longpipe=1, oitf_ready=1 -> oitf_ena=1, moitf_ena=1, alu_measure=1.
- FMR, nqf=1, qf_match=1 -> stall, qfren=1. With imm=0x5: qubitlist=8'h05.
- QWAIT with trf=6, qmr=2'b10 -> alu_clk=6, alu_qmr=2. alu_ntp follows the decoder flag.
- rs1x0=1, crf_rs1=0xDEAD -> alu_rs1=0 with QPU_DISP_X0_ZERO_EN defined, and 0xDEAD without it.
